// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding-select generation for the 5-stage MIPS pipeline.
// Shadows destination/Tnew of E, M and W; stall and mux selects are combinational.
module hazard_fwd_unit #(
    parameter int REG_W  = 5,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  d_rs,
    input  logic [REG_W-1:0]  d_rt,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [REG_W-1:0]  d_a3,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic              stall,
    output logic [1:0]        d_fwd_rs,
    output logic [1:0]        d_fwd_rt,
    output logic [1:0]        e_fwd_rs,
    output logic [1:0]        e_fwd_rt,
    output logic              m_fwd_rt
);

    localparam logic [TNEW_W-1:0] TUSE_NONE = {TNEW_W{1'b1}};
    localparam logic [REG_W-1:0]  REG_ZERO  = '0;
    localparam logic [TNEW_W-1:0] TNEW_ZERO = '0;

    logic [REG_W-1:0]  e_rs, e_rt, e_a3;
    logic [TNEW_W-1:0] e_tnew;
    logic [REG_W-1:0]  m_rt, m_a3;
    logic [TNEW_W-1:0] m_tnew;
    logic [REG_W-1:0]  w_a3;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x != TNEW_ZERO) ? x - 1'b1 : TNEW_ZERO;
    endfunction

    // A reader stalls only if a producer in E or M will not have its value by the time it is used.
    function automatic logic hazard(
        input logic [REG_W-1:0]  idx,
        input logic [TNEW_W-1:0] tuse,
        input logic [REG_W-1:0]  ea3,
        input logic [TNEW_W-1:0] etnew,
        input logic [REG_W-1:0]  ma3,
        input logic [TNEW_W-1:0] mtnew
    );
        return (idx != REG_ZERO) && (tuse != TUSE_NONE) &&
               (((ea3 == idx) && (etnew > tuse)) || ((ma3 == idx) && (mtnew > tuse)));
    endfunction

    function automatic logic [1:0] d_sel(
        input logic [REG_W-1:0]  idx,
        input logic [REG_W-1:0]  ea3,
        input logic [TNEW_W-1:0] etnew,
        input logic [REG_W-1:0]  ma3,
        input logic [TNEW_W-1:0] mtnew,
        input logic [REG_W-1:0]  wa3
    );
        if (idx == REG_ZERO)                           return 2'b00;
        else if ((ea3 == idx) && (etnew == TNEW_ZERO)) return 2'b01;
        else if ((ma3 == idx) && (mtnew == TNEW_ZERO)) return 2'b10;
        else if (wa3 == idx)                           return 2'b11;
        else                                           return 2'b00;
    endfunction

    function automatic logic [1:0] e_sel(
        input logic [REG_W-1:0]  idx,
        input logic [REG_W-1:0]  ma3,
        input logic [TNEW_W-1:0] mtnew,
        input logic [REG_W-1:0]  wa3
    );
        if (idx == REG_ZERO)                           return 2'b00;
        else if ((ma3 == idx) && (mtnew == TNEW_ZERO)) return 2'b01;
        else if (wa3 == idx)                           return 2'b10;
        else                                           return 2'b00;
    endfunction

    always_comb begin
        stall    = hazard(d_rs, d_tuse_rs, e_a3, e_tnew, m_a3, m_tnew) |
                   hazard(d_rt, d_tuse_rt, e_a3, e_tnew, m_a3, m_tnew);
        d_fwd_rs = d_sel(d_rs, e_a3, e_tnew, m_a3, m_tnew, w_a3);
        d_fwd_rt = d_sel(d_rt, e_a3, e_tnew, m_a3, m_tnew, w_a3);
        e_fwd_rs = e_sel(e_rs, m_a3, m_tnew, w_a3);
        e_fwd_rt = e_sel(e_rt, m_a3, m_tnew, w_a3);
        m_fwd_rt = (m_rt != REG_ZERO) && (w_a3 == m_rt);
    end

    // On stall E takes a bubble (a3=0), which can never match a reader.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_a3   <= '0;
            e_tnew <= '0;
            m_rt   <= '0;
            m_a3   <= '0;
            m_tnew <= '0;
            w_a3   <= '0;
        end else begin
            if (stall) begin
                e_rs   <= '0;
                e_rt   <= '0;
                e_a3   <= '0;
                e_tnew <= '0;
            end else begin
                e_rs   <= d_rs;
                e_rt   <= d_rt;
                e_a3   <= d_a3;
                e_tnew <= d_tnew;
            end
            m_rt   <= e_rt;
            m_a3   <= e_a3;
            m_tnew <= sat_dec(e_tnew);
            w_a3   <= m_a3;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: each step drives D, queues the expected
// {stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, m_fwd_rt} and compares before the next edge.
module tb_hazard_fwd_unit;

    logic       clk;
    logic       reset;
    logic [4:0] d_rs, d_rt, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       stall;
    logic [1:0] d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt;
    logic       m_fwd_rt;

    logic [9:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    hazard_fwd_unit #(.REG_W(5), .TNEW_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_a3      (d_a3),
        .d_tnew    (d_tnew),
        .stall     (stall),
        .d_fwd_rs  (d_fwd_rs),
        .d_fwd_rt  (d_fwd_rt),
        .e_fwd_rs  (e_fwd_rs),
        .e_fwd_rt  (e_fwd_rt),
        .m_fwd_rt  (m_fwd_rt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ev(input logic st, input logic [1:0] drs, input logic [1:0] drt,
                                      input logic [1:0] ers, input logic [1:0] ert, input logic mrt);
        return {st, drs, drt, ers, ert, mrt};
    endfunction

    // driver
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                         input logic [1:0] tu_rt, input logic [4:0] a3, input logic [1:0] tnew,
                         input logic [9:0] expv);
        d_rs      = rs;
        d_rt      = rt;
        d_tuse_rs = tu_rs;
        d_tuse_rt = tu_rt;
        d_a3      = a3;
        d_tnew    = tnew;
        exp_q.push_back(expv);
    endtask

    // scoreboard compare
    task automatic check(input string tag);
        logic [9:0] obs;
        logic [9:0] want;
        #1;
        obs = {stall, d_fwd_rs, d_fwd_rt, e_fwd_rs, e_fwd_rt, m_fwd_rt};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: got %b required an expectation (queue empty)", tag, obs);
        end else begin
            want = exp_q.pop_front();
            assert (obs === want) else begin
                bad++;
                $error("FAIL %s: got %b required %b (stall,dfrs,dfrt,efrs,efrt,mfrt)", tag, obs, want);
            end
        end
    endtask

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tu_rs,
                        input logic [1:0] tu_rt, input logic [4:0] a3, input logic [1:0] tnew,
                        input logic [9:0] expv, input string tag);
        @(negedge clk);
        drive(rs, rt, tu_rs, tu_rt, a3, tnew, expv);
        check(tag);
    endtask

    task automatic nop(input logic [9:0] expv, input string tag);
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, expv, tag);
    endtask

    logic [9:0] zero;

    initial begin
        zero  = '0;
        reset = 1'b1;
        drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, zero);
        #3;
        check("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // lw $1 ; addu rs=$1 (tuse 1): one stall, then W forwards into E
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, zero, "lw_issue");
        step(5'd1, 5'd0, 2'd1, 2'd1, 5'd2, 2'd1, ev(1, 0, 0, 0, 0, 0), "lw_use_stall");
        step(5'd1, 5'd0, 2'd1, 2'd1, 5'd2, 2'd1, zero, "lw_use_release");
        nop(ev(0, 0, 0, 2'b10, 0, 0), "lw_use_e_from_w");
        nop(zero, "flush1a");
        nop(zero, "flush1b");
        nop(zero, "flush1c");

        // addu $1 ; beq rs=$1 (tuse 0): one stall, then M forwards into D
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd1, zero, "alu_issue");
        step(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, ev(1, 0, 0, 0, 0, 0), "beq_stall");
        step(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, ev(0, 2'b10, 0, 0, 0, 0), "beq_d_from_m");
        nop(ev(0, 0, 0, 2'b10, 0, 0), "beq_e_from_w");
        nop(zero, "flush2");

        // two writes to $31 then jr $31: youngest (E) wins
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, zero, "jal_a");
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, zero, "jal_b");
        step(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, ev(0, 2'b01, 0, 0, 0, 0), "jr_d_from_e");
        nop(ev(0, 0, 0, 2'b01, 0, 0), "jr_e_from_m");
        nop(zero, "flush3a");
        nop(zero, "flush3b");

        // writes to $0 are never stalled on nor forwarded
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, zero, "r0_write");
        step(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, zero, "r0_read");
        nop(zero, "flush4");

        // addu $4 ; sw rt=$4 (tuse 2) back to back
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, zero, "sw_alu_issue");
        step(5'd0, 5'd4, 2'd1, 2'd2, 5'd0, 2'd0, zero, "sw_no_stall");
        nop(ev(0, 0, 0, 0, 2'b01, 0), "sw_e_from_m");
        nop(ev(0, 0, 0, 0, 0, 1'b1), "sw_m_from_w");
        nop(zero, "flush5a");

        // addu $4 ; nop ; sw rt=$4
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, zero, "swn_alu_issue");
        nop(zero, "swn_gap");
        step(5'd0, 5'd4, 2'd1, 2'd2, 5'd0, 2'd0, ev(0, 0, 2'b10, 0, 0, 0), "swn_d_from_m");
        nop(ev(0, 0, 0, 0, 2'b10, 0), "swn_e_from_w");
        nop(zero, "swn_m_no_src");
        nop(zero, "flush5b");

        // E matches with tnew>0 but no stall: falls through to M
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, zero, "ft_alu");
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, zero, "ft_lw");
        step(5'd5, 5'd0, 2'd2, 2'd3, 5'd0, 2'd0, ev(0, 2'b10, 0, 0, 0, 0), "ft_d_from_m");
        nop(ev(0, 0, 0, 2'b10, 0, 0), "ft_e_from_w");
        nop(zero, "flush6a");
        nop(zero, "flush6b");

        // producer reaches W: both D operands select W
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd0, zero, "w_prod");
        nop(zero, "w_gap1");
        nop(zero, "w_gap2");
        step(5'd6, 5'd6, 2'd0, 2'd0, 5'd0, 2'd0, ev(0, 2'b11, 2'b11, 0, 0, 0), "w_d_both");
        nop(zero, "w_e_gone");
        nop(zero, "flush7a");
        nop(zero, "flush7b");

        // asynchronous reset in the middle of a load-use stall
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, zero, "rst_lw_issue");
        step(5'd1, 5'd0, 2'd1, 2'd1, 5'd2, 2'd1, ev(1, 0, 0, 0, 0, 0), "rst_pre_stall");
        #1;
        reset = 1'b1;
        exp_q.push_back(zero);
        check("rst_async_clear");
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(zero);
        check("rst_release_no_hazard");
        nop(zero, "rst_after_adv");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
